// File: rtl/fpu_issue_sched.sv
// Launches one multi-cycle FPU op at a time, counts its fixed latency and arbitrates the shared RF write port.
// Result is granted at issue+L+1 at the earliest; the ALU is preempted after MAX_WAIT denied cycles; decode stalls on busy/RAW/WAW.
module fpu_issue_sched #(
  parameter int ADD_LAT  = 3,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 16,
  parameter int MISC_LAT = 1,
  parameter int MAX_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_alu_fpu,
  input  logic       id_reg_write,
  input  logic [4:0] id_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_funct5,
  input  logic       flush,
  input  logic       alu_wb_valid,
  output logic       stall,
  output logic       fpu_start,
  output logic       fpu_capture,
  output logic       fpu_kill,
  output logic       wb_fpu_valid,
  output logic [4:0] wb_fpu_rd,
  output logic       alu_wb_hold,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t     state_q, state_d;
  logic [4:0] pend_rd_q, pend_rd_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [4:0] lat_m1;
  logic       hazard;

  always_comb begin
    case (id_funct5)
      5'b00000, 5'b00001: lat_m1 = 5'(ADD_LAT - 1);
      5'b00010:           lat_m1 = 5'(MUL_LAT - 1);
      5'b00011:           lat_m1 = 5'(DIV_LAT - 1);
      default:            lat_m1 = 5'(MISC_LAT - 1);
    endcase
  end

  // x0 is never a real dependency, so a pending rd of 0 never stalls decode
  assign hazard = (state_q != IDLE) && (pend_rd_q != 5'd0) &&
                  ((id_rs1 == pend_rd_q) || (id_rs2 == pend_rd_q) ||
                   (id_reg_write && (id_rd == pend_rd_q)));
  assign stall  = id_valid && ((id_alu_fpu && (state_q != IDLE)) || hazard);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    pend_rd_d    = pend_rd_q;
    cnt_d        = cnt_q;
    wait_cnt_d   = wait_cnt_q;
    fpu_start    = 1'b0;
    fpu_capture  = 1'b0;
    fpu_kill     = 1'b0;
    wb_fpu_valid = 1'b0;
    alu_wb_hold  = 1'b0;
    wb_fpu_rd    = 5'd0;

    case (state_q)
      IDLE: begin
        if (id_valid && id_alu_fpu && !flush) begin
          fpu_start = 1'b1;
          pend_rd_d = id_rd;
          cnt_d     = lat_m1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          fpu_kill = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == 5'd0) begin
          fpu_capture = 1'b1;
          wait_cnt_d  = 4'd0;
          state_d     = WB;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      WB: begin
        if (flush) begin
          fpu_kill = 1'b1;
          state_d  = IDLE;
        end else if (pend_rd_q == 5'd0) begin
          state_d = IDLE;
        end else if (!alu_wb_valid) begin
          wb_fpu_valid = 1'b1;
          state_d      = IDLE;
        end else if (wait_cnt_q == 4'(MAX_WAIT)) begin
          wb_fpu_valid = 1'b1;
          alu_wb_hold  = 1'b1;
          state_d      = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wb_fpu_valid) wb_fpu_rd = pend_rd_q;

    // reset silently drops any in-flight op; no pulse may escape in that cycle
    if (rst) begin
      fpu_start    = 1'b0;
      fpu_capture  = 1'b0;
      fpu_kill     = 1'b0;
      wb_fpu_valid = 1'b0;
      alu_wb_hold  = 1'b0;
      wb_fpu_rd    = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_rd_q  <= 5'd0;
      cnt_q      <= 5'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched with hand-computed cycle-by-cycle expectations.
module tb_fpu_issue_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_alu_fpu, id_reg_write, flush, alu_wb_valid;
  logic [4:0] id_rd, id_rs1, id_rs2, id_funct5;
  logic       stall, fpu_start, fpu_capture, fpu_kill, wb_fpu_valid, alu_wb_hold, busy;
  logic [4:0] wb_fpu_rd;

  int n_cmp = 0;
  int n_err = 0;

  fpu_issue_sched dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_alu_fpu(id_alu_fpu), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct5(id_funct5),
    .flush(flush), .alu_wb_valid(alu_wb_valid),
    .stall(stall), .fpu_start(fpu_start), .fpu_capture(fpu_capture), .fpu_kill(fpu_kill),
    .wb_fpu_valid(wb_fpu_valid), .wb_fpu_rd(wb_fpu_rd), .alu_wb_hold(alu_wb_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_alu_fpu = 0; id_reg_write = 0;
    id_rd = 0; id_rs1 = 0; id_rs2 = 0; id_funct5 = 0;
    flush = 0; alu_wb_valid = 0;
  endtask

  task automatic present_fpu(input logic [4:0] f5, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_alu_fpu = 1; id_reg_write = 1;
    id_funct5 = f5; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic present_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_alu_fpu = 0; id_reg_write = 1;
    id_funct5 = 5'b00000; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"}, fpu_start, 0);
    chk({tag, "_cap"},   fpu_capture, 0);
    chk({tag, "_kill"},  fpu_kill, 0);
    chk({tag, "_wbv"},   wb_fpu_valid, 0);
    chk({tag, "_wbrd"},  wb_fpu_rd, 0);
    chk({tag, "_hold"},  alu_wb_hold, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    #1;
    chk_quiet("reset");
    chk("reset_stall", stall, 0);

    // fmul rd=5: start@T, capture@T+4, grant@T+5, idle@T+6
    present_fpu(5'b00010, 5'd5, 5'd1, 5'd2);
    #1;
    chk("fmul_start", fpu_start, 1);
    chk("fmul_stall0", stall, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      idle_inputs();
      #1;
      chk("fmul_start_k", fpu_start, 0);
      chk("fmul_cap", fpu_capture, k == 4);
      chk("fmul_wbv", wb_fpu_valid, k == 5);
      chk("fmul_wbrd", wb_fpu_rd, (k == 5) ? 5 : 0);
      chk("fmul_busy", busy, k <= 5);
    end

    // fdiv rd=7: dependent add stalls through grant (T+17), independent add never stalls
    present_fpu(5'b00011, 5'd7, 5'd3, 5'd4);
    #1;
    chk("fdiv_start", fpu_start, 1);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      present_alu(5'd8, 5'd7, 5'd1);
      #1;
      chk("fdiv_dep_stall", stall, k <= 17);
      chk("fdiv_cap", fpu_capture, k == 16);
      chk("fdiv_wbv", wb_fpu_valid, k == 17);
      chk("fdiv_wbrd", wb_fpu_rd, (k == 17) ? 7 : 0);
      present_alu(5'd9, 5'd1, 5'd2);
      #1;
      chk("fdiv_indep_stall", stall, 0);
    end
    idle_inputs();

    // fadd rd=3 with ALU holding the port: two denied WB cycles, preempt on the third
    cyc();
    present_fpu(5'b00000, 5'd3, 5'd1, 5'd2);
    alu_wb_valid = 1;
    #1;
    chk("fadd_start", fpu_start, 1);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      idle_inputs();
      alu_wb_valid = 1;
      #1;
      chk("fadd_cap", fpu_capture, k == 3);
      chk("fadd_wbv", wb_fpu_valid, k == 6);
      chk("fadd_hold", alu_wb_hold, k == 6);
      chk("fadd_wbrd", wb_fpu_rd, (k == 6) ? 3 : 0);
      chk("fadd_busy", busy, k <= 6);
    end
    idle_inputs();

    // second FPU op during BUSY waits until the cycle after the first grant
    cyc();
    present_fpu(5'b00010, 5'd10, 5'd1, 5'd2);
    #1;
    chk("b2b_start0", fpu_start, 1);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k <= 6) present_fpu(5'b00000, 5'd11, 5'd12, 5'd13);
      else idle_inputs();
      #1;
      chk("b2b_stall", stall, (k >= 1) && (k <= 5));
      chk("b2b_start", fpu_start, k == 6);
      chk("b2b_wbv", wb_fpu_valid, (k == 5) || (k == 10));
      chk("b2b_wbrd", wb_fpu_rd, (k == 5) ? 10 : (k == 10) ? 11 : 0);
    end
    idle_inputs();

    // flush two cycles after fdiv issue
    cyc();
    present_fpu(5'b00011, 5'd7, 5'd1, 5'd2);
    #1;
    chk("fl_start", fpu_start, 1);
    cyc();
    idle_inputs();
    cyc();
    flush = 1;
    #1;
    chk("fl_kill", fpu_kill, 1);
    chk("fl_wbv", wb_fpu_valid, 0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      flush = 0;
      #1;
      chk("fl_after_busy", busy, 0);
      chk("fl_after_wbv", wb_fpu_valid, 0);
      chk("fl_after_kill", fpu_kill, 0);
    end

    // flush in IDLE suppresses issue
    present_fpu(5'b00010, 5'd4, 5'd1, 5'd2);
    flush = 1;
    #1;
    chk("fli_start", fpu_start, 0);
    chk("fli_kill", fpu_kill, 0);
    cyc();
    idle_inputs();
    #1;
    chk("fli_busy", busy, 0);

    // reset mid-BUSY, with flush asserted: no kill, idle next edge
    present_fpu(5'b00011, 5'd6, 5'd1, 5'd2);
    #1;
    chk("rb_start", fpu_start, 1);
    cyc();
    idle_inputs();
    cyc();
    rst = 1;
    flush = 1;
    #1;
    chk("rb_kill_in_rst", fpu_kill, 0);
    chk("rb_cap_in_rst", fpu_capture, 0);
    cyc();
    rst = 0;
    flush = 0;
    #1;
    chk_quiet("rb_after");

    // MISC op rd=0: capture@T+1, discarded, no x0 stall, idle@T+3
    present_fpu(5'b10100, 5'd0, 5'd0, 5'd0);
    #1;
    chk("misc_start", fpu_start, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      present_alu(5'd0, 5'd0, 5'd0);
      #1;
      chk("misc_cap", fpu_capture, k == 1);
      chk("misc_wbv", wb_fpu_valid, 0);
      chk("misc_stall", stall, 0);
      chk("misc_busy", busy, k <= 2);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
- Issue sequencer and writeback arbiter for multi-cycle FPU ops (alu_fpu=1, opcode 1010011).
- Sits between decode and the FPU:
  - launches one FPU op at a time and counts its fixed latency;
  - raises a decode stall on structural and RAW/WAW hazards against the pending destination;
  - shares the single register-file write port with the ALU writeback path.

Parameters:
- ADD_LAT, 3, cycles for funct5 00000/00001 (fadd/fsub); legal 1..31
- MUL_LAT, 4, cycles for funct5 00010 (fmul); legal 1..31
- DIV_LAT, 16, cycles for funct5 00011 (fdiv); legal 1..31
- MISC_LAT, 1, cycles for every other funct5; legal 1..31
- MAX_WAIT, 2, cycles the FPU result may be denied the write port before it preempts the ALU; legal 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_alu_fpu  in  1  decoded FPU instruction
- id_reg_write  in  1  decoded instruction writes rd
- id_rd  in  5  destination register
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_funct5  in  5  instr[31:27]
- flush  in  1  pipeline flush (branch/jump redirect)
- alu_wb_valid  in  1  ALU path writes the register file this cycle
- stall  out  1  freeze fetch/decode
- fpu_start  out  1  one-cycle launch pulse to FPU
- fpu_capture  out  1  one-cycle pulse: latch FPU result
- fpu_kill  out  1  abort pending FPU op
- wb_fpu_valid  out  1  FPU result owns write port this cycle
- wb_fpu_rd  out  5  destination for FPU writeback
- alu_wb_hold  out  1  ALU writeback preempted; ALU stage holds its result
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, WB. Registers: pend_rd[4:0], cnt[4:0], wait_cnt[3:0].
- Reset (rst=1 at posedge, from any state, including mid-operation):
  - state=IDLE; pend_rd, cnt and wait_cnt=0.
  - All registered outputs 0. No kill pulse is issued on reset.
- hazard = (state!=IDLE) & (pend_rd!=0) & (id_rs1==pend_rd | id_rs2==pend_rd | (id_reg_write & id_rd==pend_rd)).
- stall = id_valid & ((id_alu_fpu & state!=IDLE) | hazard). Combinational.
- Issue cycle T:
  - Condition: state==IDLE & id_valid & id_alu_fpu & !flush.
  - fpu_start=1 combinationally; latency L selected from id_funct5.
  - At the clock edge: pend_rd<=id_rd, cnt<=L-1, state<=BUSY.
- BUSY:
  - cnt==0: fpu_capture=1, wait_cnt<=0, state<=WB.
  - Otherwise cnt<=cnt-1.
  - Result: fpu_capture fires at exactly T+L.
- WB:
  - pend_rd==0: result discarded, no port request, state<=IDLE.
  - Else if !alu_wb_valid: wb_fpu_valid=1, state<=IDLE.
  - Else if wait_cnt==MAX_WAIT: wb_fpu_valid=1 and alu_wb_hold=1 in the same cycle, state<=IDLE.
  - Else wait_cnt<=wait_cnt+1 and stay in WB.
- wb_fpu_rd=pend_rd whenever wb_fpu_valid=1, else 0.
- busy=1 in BUSY and WB.
- Earliest grant is T+L+1. Earliest next issue is the cycle after the grant cycle (state back in IDLE).
- Hazard stall persists through the grant cycle and clears once state is IDLE.
- Flush:
  - In BUSY or WB: fpu_kill=1 combinationally, no writeback, state<=IDLE.
  - Flush beats capture and grant in the same cycle.
  - In IDLE: fpu_kill=0 and the issue is suppressed.
- All outputs other than the registered state are combinational from state/inputs. fpu_start, fpu_capture, wb_fpu_valid, alu_wb_hold and fpu_kill never assert when rst=1.

Test Plan:
- fmul (funct5=00010) rd=5 issued at T, alu_wb_valid=0 -> fpu_start@T, fpu_capture@T+4, wb_fpu_valid=1 wb_fpu_rd=5 @T+5, busy low @T+6.
- fdiv rd=7 in flight, then decode add x8,x7,x1 -> stall=1 until the grant cycle (T+17) inclusive, stall=0 @T+18; a non-dependent add x9,x1,x2 -> stall=0 throughout.
- fadd rd=3 reaches WB with alu_wb_valid held 1, MAX_WAIT=2 -> two wait cycles, third WB cycle wb_fpu_valid=1 and alu_wb_hold=1.
- Second FPU op decoded during BUSY -> stall=1, no fpu_start until the cycle after the first op's grant.
- flush 2 cycles after an fdiv issue -> fpu_kill=1 that cycle, never wb_fpu_valid, busy=0 next cycle; rst mid-BUSY -> IDLE next edge, all outputs 0.
- MISC op (funct5=10100) with rd=0 -> fpu_capture@T+1, no wb_fpu_valid, no hazard stall on rs=x0, IDLE @T+3.
